// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port arbiter in front of a single-cycle RAM, with starvation-driven
// priority swap, per-request legality checking and registered one-cycle responses.
module mem_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        p0_req,
    input  logic        p0_we,
    input  logic [31:0] p0_addr,
    input  logic [31:0] p0_wdata,
    input  logic [2:0]  p0_mode,
    output logic        p0_gnt,
    output logic        p0_rvalid,
    output logic        p0_rerr,
    output logic [31:0] p0_rdata,
    input  logic        p1_req,
    input  logic        p1_we,
    input  logic [31:0] p1_addr,
    input  logic [31:0] p1_wdata,
    input  logic [2:0]  p1_mode,
    output logic        p1_gnt,
    output logic        p1_rvalid,
    output logic        p1_rerr,
    output logic [31:0] p1_rdata,
    output logic        ram_we,
    output logic [31:0] ram_addr,
    output logic [2:0]  ram_mode,
    output logic [31:0] ram_din,
    input  logic [31:0] ram_dout
);
    typedef enum logic {P0_PRI, P1_PRI} pri_e;

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    pri_e        state_q;
    logic [3:0]  starve_q, starve_d;
    logic        legal0, legal1;
    logic        p0_rvalid_q, p1_rvalid_q, p0_rerr_q, p1_rerr_q;
    logic [31:0] p0_rdata_q, p1_rdata_q;

    function automatic logic is_legal(input logic [1:0] lo, input logic [2:0] mode);
        return mode == 3'd0 || mode == 3'd4 ||
               ((mode == 3'd1 || mode == 3'd5) && !lo[0]) ||
               (mode == 3'd2 && lo == 2'b00);
    endfunction

    assign legal0 = is_legal(p0_addr[1:0], p0_mode);
    assign legal1 = is_legal(p1_addr[1:0], p1_mode);

    // Reset masks both requests so nothing is granted or written while rst is high.
    assign p1_gnt = !rst && p1_req && (!p0_req || state_q == P1_PRI);
    assign p0_gnt = !rst && p0_req && !p1_gnt;

    assign ram_we   = p0_gnt ? p0_we && legal0 : p1_gnt && p1_we && legal1;
    assign ram_addr = p0_gnt ? p0_addr  : p1_gnt ? p1_addr  : 32'd0;
    assign ram_mode = p0_gnt ? p0_mode  : p1_gnt ? p1_mode  : 3'd0;
    assign ram_din  = p0_gnt ? p0_wdata : p1_gnt ? p1_wdata : 32'd0;

    assign starve_d = (p1_req && !p1_gnt) ? (starve_q == LIMIT ? LIMIT : starve_q + 4'd1) : 4'd0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= P0_PRI;
            starve_q    <= 4'd0;
            p0_rvalid_q <= 1'b0;
            p1_rvalid_q <= 1'b0;
            p0_rerr_q   <= 1'b0;
            p1_rerr_q   <= 1'b0;
            p0_rdata_q  <= 32'd0;
            p1_rdata_q  <= 32'd0;
        end else begin
            starve_q    <= starve_d;
            state_q     <= p1_gnt ? P0_PRI : (starve_d == LIMIT ? P1_PRI : state_q);
            p0_rvalid_q <= p0_gnt;
            p1_rvalid_q <= p1_gnt;
            p0_rerr_q   <= p0_gnt && !legal0;
            p1_rerr_q   <= p1_gnt && !legal1;
            // A legal write leaves the last load result in place.
            if (p0_gnt && !(p0_we && legal0)) p0_rdata_q <= legal0 ? ram_dout : 32'd0;
            if (p1_gnt && !(p1_we && legal1)) p1_rdata_q <= legal1 ? ram_dout : 32'd0;
        end
    end

    assign p0_rvalid = p0_rvalid_q;
    assign p1_rvalid = p1_rvalid_q;
    assign p0_rerr   = p0_rerr_q;
    assign p1_rerr   = p1_rerr_q;
    assign p0_rdata  = p0_rdata_q;
    assign p1_rdata  = p1_rdata_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scenarios plus randomized traffic checked against a
// behavioural arbitration/memory model; the bench also plays the RAM.
module tb_mem_arbiter;
    localparam int LIMIT = 4;

    logic        clk = 1'b0, rst, clr;
    logic        p0_req, p0_we, p1_req, p1_we;
    logic [31:0] p0_addr, p0_wdata, p1_addr, p1_wdata;
    logic [2:0]  p0_mode, p1_mode;
    logic        p0_gnt, p1_gnt, p0_rvalid, p1_rvalid, p0_rerr, p1_rerr;
    logic [31:0] p0_rdata, p1_rdata;
    logic        ram_we;
    logic [31:0] ram_addr, ram_din, ram_dout;
    logic [2:0]  ram_mode;

    int n_cmp = 0, n_err = 0;

    logic [7:0] mem [256];
    logic [7:0] sh [256];
    logic [7:0] ra;

    bit          m_p1pri, e_g0, e_g1, e_rv0, e_rv1, e_re0, e_re1;
    int          m_starve;
    logic [69:0] e_cv;
    logic [31:0] e_rd0, e_rd1;

    mem_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .rst(rst),
        .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata), .p0_mode(p0_mode),
        .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid), .p0_rerr(p0_rerr), .p0_rdata(p0_rdata),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata), .p1_mode(p1_mode),
        .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_rerr(p1_rerr), .p1_rdata(p1_rdata),
        .ram_we(ram_we), .ram_addr(ram_addr), .ram_mode(ram_mode), .ram_din(ram_din),
        .ram_dout(ram_dout)
    );

    always #5 clk = ~clk;

    // Little-endian byte RAM, 256 bytes, read data extended per mode.
    assign ra = ram_addr[7:0];
    assign ram_dout = ram_mode[1:0] == 2'd2 ? {mem[ra + 8'd3], mem[ra + 8'd2], mem[ra + 8'd1], mem[ra]}
                    : ram_mode[1:0] == 2'd1 ? {{16{!ram_mode[2] && mem[ra + 8'd1][7]}}, mem[ra + 8'd1], mem[ra]}
                    : {{24{!ram_mode[2] && mem[ra][7]}}, mem[ra]};

    always @(posedge clk) begin
        if (clr) begin
            for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
        end else if (ram_we) begin
            mem[ra] <= ram_din[7:0];
            if (ram_mode[1:0] != 2'd0) mem[ra + 8'd1] <= ram_din[15:8];
            if (ram_mode[1:0] == 2'd2) begin
                mem[ra + 8'd2] <= ram_din[23:16];
                mem[ra + 8'd3] <= ram_din[31:24];
            end
        end
    end

    function automatic bit legal(input logic [31:0] a, input logic [2:0] m);
        case (m)
            3'd0, 3'd4: return 1'b1;
            3'd1, 3'd5: return a % 2 == 0;
            3'd2:       return a % 4 == 0;
            default:    return 1'b0;
        endcase
    endfunction

    function automatic int nbytes(input logic [2:0] m);
        return m[1:0] == 2'd2 ? 4 : m[1:0] == 2'd1 ? 2 : 1;
    endfunction

    function automatic logic [31:0] sh_read(input logic [31:0] a, input logic [2:0] m);
        logic [31:0] v;
        int n;
        v = 32'd0;
        n = nbytes(m);
        for (int i = 0; i < n; i++) v[8*i +: 8] = sh[8'(a + 32'(i))];
        if (!m[2] && n < 4 && v[8*n-1])
            for (int i = n; i < 4; i++) v[8*i +: 8] = 8'hFF;
        return v;
    endfunction

    task automatic access(input logic we, input logic [31:0] a, input logic [2:0] m,
                          input logic [31:0] wd, inout logic [31:0] rd);
        if (!legal(a, m)) rd = 32'd0;
        else if (we) for (int i = 0; i < nbytes(m); i++) sh[8'(a + 32'(i))] = wd[8*i +: 8];
        else rd = sh_read(a, m);
    endtask

    task automatic model_comb();
        bit r0, r1;
        r0 = p0_req && !rst;
        r1 = p1_req && !rst;
        e_g1 = r1 && (!r0 || m_p1pri);
        e_g0 = r0 && !e_g1;
        e_cv = '0;
        if (e_g0) e_cv = {2'b10, p0_we && legal(p0_addr, p0_mode), p0_addr, p0_mode, p0_wdata};
        if (e_g1) e_cv = {2'b01, p1_we && legal(p1_addr, p1_mode), p1_addr, p1_mode, p1_wdata};
    endtask

    task automatic model_edge();
        if (rst) begin
            m_p1pri = 1'b0; m_starve = 0;
            e_rv0 = 1'b0; e_rv1 = 1'b0; e_re0 = 1'b0; e_re1 = 1'b0;
            e_rd0 = 32'd0; e_rd1 = 32'd0;
        end else begin
            e_rv0 = e_g0;
            e_rv1 = e_g1;
            e_re0 = e_g0 && !legal(p0_addr, p0_mode);
            e_re1 = e_g1 && !legal(p1_addr, p1_mode);
            if (e_g0) access(p0_we, p0_addr, p0_mode, p0_wdata, e_rd0);
            if (e_g1) access(p1_we, p1_addr, p1_mode, p1_wdata, e_rd1);
            m_starve = (p1_req && !e_g1) ? (m_starve + 1 > LIMIT ? LIMIT : m_starve + 1) : 0;
            if (e_g1) m_p1pri = 1'b0;
            else if (m_starve == LIMIT) m_p1pri = 1'b1;
        end
    endtask

    task automatic settle();
        model_comb();
        @(negedge clk);
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic cyc();
        settle();
        tick();
    endtask

    task automatic set_p(input int n, input logic req, input logic we, input logic [31:0] addr,
                         input logic [2:0] mode, input logic [31:0] wdata);
        if (n == 0) begin
            p0_req = req; p0_we = we; p0_addr = addr; p0_mode = mode; p0_wdata = wdata;
        end else begin
            p1_req = req; p1_we = we; p1_addr = addr; p1_mode = mode; p1_wdata = wdata;
        end
    endtask

    task automatic idle();
        set_p(0, 1'b0, 1'b0, 32'd0, 3'd0, 32'd0);
        set_p(1, 1'b0, 1'b0, 32'd0, 3'd0, 32'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle();
        cyc();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int k = 0; k < 2; k++) begin
            set_p(0, 1'b1, 1'b1, 32'h20, 3'd2, 32'hCAFE0000);
            set_p(1, 1'(k), 1'b1, 32'h24, 3'd2, 32'h0000BEEF);
            settle();
            n_cmp++;
            if ({p0_gnt, p1_gnt, ram_we} !== 3'b000) begin
                n_err++;
                $display("FAIL reset_gnt k=%0d got %b%b%b expected 000", k, p0_gnt, p1_gnt, ram_we);
            end
            tick();
            n_cmp++;
            if ({p0_rvalid, p1_rvalid, p0_rerr, p1_rerr, p0_rdata, p1_rdata} !== 68'd0) begin
                n_err++;
                $display("FAIL reset_regs got rv=%b%b re=%b%b rd0=%h rd1=%h expected all 0",
                         p0_rvalid, p1_rvalid, p0_rerr, p1_rerr, p0_rdata, p1_rdata);
            end
        end
        rst = 1'b0;
        idle();
        cyc();
    endtask

    task automatic test_write_read();
        do_reset();
        set_p(0, 1'b1, 1'b1, 32'h10, 3'd2, 32'h11223344);
        settle();
        n_cmp++;
        if ({p0_gnt, p1_gnt, ram_we, ram_addr, ram_din} !== {3'b101, 32'h10, 32'h11223344}) begin
            n_err++;
            $display("FAIL wr_cmd got g=%b%b we=%b a=%h d=%h expected 10 1 00000010 11223344",
                     p0_gnt, p1_gnt, ram_we, ram_addr, ram_din);
        end
        tick();
        n_cmp++;
        if ({p0_rvalid, p0_rerr, p0_rdata} !== {2'b10, 32'd0}) begin
            n_err++;
            $display("FAIL wr_resp got rv=%b re=%b rd=%h expected 1 0 00000000", p0_rvalid, p0_rerr, p0_rdata);
        end
        set_p(0, 1'b0, 1'b0, 32'd0, 3'd0, 32'd0);
        set_p(1, 1'b1, 1'b0, 32'h13, 3'd4, 32'd0);
        settle();
        n_cmp++;
        if ({p0_gnt, p1_gnt, ram_we, ram_mode} !== {3'b010, 3'd4}) begin
            n_err++;
            $display("FAIL rd_cmd got g=%b%b we=%b m=%0d expected 01 0 4", p0_gnt, p1_gnt, ram_we, ram_mode);
        end
        tick();
        n_cmp++;
        if ({p0_rvalid, p1_rvalid, p1_rerr, p1_rdata} !== {3'b010, 32'h00000011}) begin
            n_err++;
            $display("FAIL rd_resp got rv=%b%b re=%b rd=%h expected 01 0 00000011",
                     p0_rvalid, p1_rvalid, p1_rerr, p1_rdata);
        end
        idle();
        cyc();
        n_cmp++;
        if ({p1_rvalid, p1_rdata} !== {1'b0, 32'h00000011}) begin
            n_err++;
            $display("FAIL rd_hold got rv=%b rd=%h expected 0 00000011", p1_rvalid, p1_rdata);
        end
    endtask

    task automatic test_starve();
        bit want1;
        do_reset();
        set_p(0, 1'b1, 1'b0, 32'h10, 3'd2, 32'd0);
        set_p(1, 1'b1, 1'b0, 32'h14, 3'd2, 32'd0);
        for (int c = 0; c < 3 * (LIMIT + 1); c++) begin
            want1 = (c % (LIMIT + 1)) == LIMIT;
            settle();
            n_cmp++;
            if ({p0_gnt, p1_gnt} !== {!want1, want1}) begin
                n_err++;
                $display("FAIL starve_gnt c=%0d got %b%b expected %b%b", c, p0_gnt, p1_gnt, !want1, want1);
            end
            tick();
            n_cmp++;
            if ({p0_rvalid, p1_rvalid} !== {!want1, want1}) begin
                n_err++;
                $display("FAIL starve_rv c=%0d got %b%b expected %b%b", c, p0_rvalid, p1_rvalid, !want1, want1);
            end
        end
        idle();
        cyc();
    endtask

    task automatic test_illegal();
        logic [31:0] ia [5] = '{32'h10, 32'h10, 32'h10, 32'h11, 32'h12};
        logic [2:0]  im [5] = '{3'd3, 3'd6, 3'd7, 3'd1, 3'd2};
        do_reset();
        set_p(0, 1'b1, 1'b0, 32'h10, 3'd2, 32'd0);
        cyc();
        set_p(0, 1'b1, 1'b0, 32'h02, 3'd2, 32'd0);
        settle();
        n_cmp++;
        if ({p0_gnt, ram_we} !== 2'b10) begin
            n_err++;
            $display("FAIL ill_rd_cmd got g=%b we=%b expected 1 0", p0_gnt, ram_we);
        end
        tick();
        n_cmp++;
        if ({p0_rvalid, p0_rerr, p0_rdata} !== {2'b11, 32'd0}) begin
            n_err++;
            $display("FAIL ill_rd_resp got rv=%b re=%b rd=%h expected 1 1 00000000", p0_rvalid, p0_rerr, p0_rdata);
        end
        for (int i = 0; i < 5; i++) begin
            set_p(0, 1'b1, 1'b1, ia[i], im[i], 32'hDEADBEEF);
            settle();
            n_cmp++;
            if ({p0_gnt, ram_we} !== 2'b10) begin
                n_err++;
                $display("FAIL ill_wr_cmd i=%0d got g=%b we=%b expected 1 0", i, p0_gnt, ram_we);
            end
            tick();
            n_cmp++;
            if ({p0_rvalid, p0_rerr} !== 2'b11) begin
                n_err++;
                $display("FAIL ill_wr_resp i=%0d got rv=%b re=%b expected 1 1", i, p0_rvalid, p0_rerr);
            end
        end
        set_p(0, 1'b1, 1'b0, 32'h10, 3'd2, 32'd0);
        cyc();
        n_cmp++;
        if ({p0_rerr, p0_rdata} !== {1'b0, 32'h11223344}) begin
            n_err++;
            $display("FAIL ill_intact got re=%b rd=%h expected 0 11223344", p0_rerr, p0_rdata);
        end
        idle();
        cyc();
    endtask

    task automatic test_signed_half();
        logic [31:0] a  [4] = '{32'h22, 32'h22, 32'h23, 32'h23};
        logic [2:0]  m  [4] = '{3'd1, 3'd5, 3'd1, 3'd0};
        logic [32:0] ex [4] = '{{1'b0, 32'hFFFF8001}, {1'b0, 32'h00008001}, {1'b1, 32'h0}, {1'b0, 32'hFFFFFF80}};
        do_reset();
        set_p(1, 1'b1, 1'b1, 32'h22, 3'd1, 32'h12348001);
        cyc();
        for (int i = 0; i < 4; i++) begin
            set_p(1, 1'b1, 1'b0, a[i], m[i], 32'd0);
            cyc();
            n_cmp++;
            if ({p1_rvalid, p1_rerr, p1_rdata} !== {1'b1, ex[i]}) begin
                n_err++;
                $display("FAIL half_rd i=%0d got rv=%b re=%b rd=%h expected 1 %b %h",
                         i, p1_rvalid, p1_rerr, p1_rdata, ex[i][32], ex[i][31:0]);
            end
        end
        idle();
        cyc();
    endtask

    task automatic test_reset_in_grant();
        bit want1;
        do_reset();
        set_p(0, 1'b1, 1'b0, 32'h40, 3'd2, 32'd0);
        set_p(1, 1'b1, 1'b0, 32'h44, 3'd2, 32'd0);
        for (int c = 0; c < LIMIT - 1; c++) cyc();
        rst = 1'b1;
        set_p(0, 1'b1, 1'b1, 32'h40, 3'd2, 32'hAABBCCDD);
        settle();
        n_cmp++;
        if ({p0_gnt, p1_gnt, ram_we} !== 3'b000) begin
            n_err++;
            $display("FAIL rig_cmd got g=%b%b we=%b expected 00 0", p0_gnt, p1_gnt, ram_we);
        end
        tick();
        n_cmp++;
        if ({p0_rvalid, p1_rvalid} !== 2'b00) begin
            n_err++;
            $display("FAIL rig_rv got %b%b expected 00", p0_rvalid, p1_rvalid);
        end
        rst = 1'b0;
        set_p(0, 1'b1, 1'b0, 32'h40, 3'd2, 32'd0);
        for (int c = 0; c <= LIMIT; c++) begin
            want1 = c == LIMIT;
            settle();
            n_cmp++;
            if ({p0_gnt, p1_gnt} !== {!want1, want1}) begin
                n_err++;
                $display("FAIL rig_pri c=%0d got %b%b expected %b%b", c, p0_gnt, p1_gnt, !want1, want1);
            end
            tick();
        end
        n_cmp++;
        if ({p0_rerr, p0_rdata} !== 33'd0) begin
            n_err++;
            $display("FAIL rig_ram got re=%b rd=%h expected 0 00000000", p0_rerr, p0_rdata);
        end
        idle();
        cyc();
    endtask

    task automatic test_back_to_back();
        logic [31:0] a  [5] = '{32'h30, 32'h30, 32'h31, 32'h30, 32'h30};
        logic [2:0]  m  [5] = '{3'd0, 3'd4, 3'd0, 3'd0, 3'd5};
        logic        w  [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        logic [31:0] wd [5] = '{32'h9C, 32'h0, 32'h11, 32'h0, 32'h0};
        logic [31:0] ex [5] = '{32'h0, 32'h9C, 32'h9C, 32'hFFFFFF9C, 32'h0000119C};
        do_reset();
        for (int i = 0; i < 5; i++) begin
            set_p(1, 1'b1, w[i], a[i], m[i], wd[i]);
            settle();
            n_cmp++;
            if (p1_gnt !== 1'b1) begin
                n_err++;
                $display("FAIL b2b_gnt i=%0d got %b expected 1", i, p1_gnt);
            end
            tick();
            n_cmp++;
            if ({p1_rvalid, p1_rerr, p1_rdata} !== {2'b10, ex[i]}) begin
                n_err++;
                $display("FAIL b2b_resp i=%0d got rv=%b re=%b rd=%h expected 1 0 %h",
                         i, p1_rvalid, p1_rerr, p1_rdata, ex[i]);
            end
        end
        idle();
        cyc();
        n_cmp++;
        if ({p1_rvalid, p1_rdata} !== {1'b0, 32'h0000119C}) begin
            n_err++;
            $display("FAIL b2b_end got rv=%b rd=%h expected 0 0000119C", p1_rvalid, p1_rdata);
        end
    endtask

    task automatic test_random();
        bit pend0 = 1'b0, pend1 = 1'b0;
        for (int c = 0; c < 600; c++) begin
            if (!pend0)
                set_p(0, 1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 1)),
                      32'($urandom_range(0, 63)), 3'($urandom_range(0, 7)), $urandom);
            if (!pend1)
                set_p(1, 1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 1)),
                      32'($urandom_range(0, 63)), 3'($urandom_range(0, 7)), $urandom);
            rst = $urandom_range(0, 39) == 0;
            settle();
            n_cmp++;
            if ({p0_gnt, p1_gnt, ram_we, ram_addr, ram_mode, ram_din} !== e_cv) begin
                n_err++;
                $display("FAIL rnd_cmd c=%0d got %b%b %b %h %0d %h expected %h",
                         c, p0_gnt, p1_gnt, ram_we, ram_addr, ram_mode, ram_din, e_cv);
            end
            pend0 = p0_req && !e_g0;
            pend1 = p1_req && !e_g1;
            tick();
            n_cmp++;
            if ({p0_rvalid, p1_rvalid, p0_rerr, p1_rerr, p0_rdata, p1_rdata} !==
                {e_rv0, e_rv1, e_re0, e_re1, e_rd0, e_rd1}) begin
                n_err++;
                $display("FAIL rnd_resp c=%0d got rv=%b%b re=%b%b rd=%h/%h expected rv=%b%b re=%b%b rd=%h/%h",
                         c, p0_rvalid, p1_rvalid, p0_rerr, p1_rerr, p0_rdata, p1_rdata,
                         e_rv0, e_rv1, e_re0, e_re1, e_rd0, e_rd1);
            end
        end
        rst = 1'b0;
        idle();
        cyc();
    endtask

    initial begin
        for (int i = 0; i < 256; i++) sh[i] = 8'h00;
        m_p1pri = 1'b0; m_starve = 0;
        e_rv0 = 1'b0; e_rv1 = 1'b0; e_re0 = 1'b0; e_re1 = 1'b0;
        e_rd0 = 32'd0; e_rd1 = 32'd0;
        rst = 1'b1;
        clr = 1'b1;
        idle();
        @(posedge clk);
        #1;
        clr = 1'b0;
        test_reset();
        test_write_read();
        test_starve();
        test_illegal();
        test_signed_half();
        test_reset_in_grant();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have parameter STARVE_LIMIT, default 4, giving the consecutive denied cycles after which port 1 gains priority (range 1..15).
REQ-002 The block SHALL have port clk, input, 1 bit, the clock; every register samples on the rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit, the reset: synchronous and active-high.
REQ-004 The block SHALL have ports pN_req, pN_we, input, 1 bit each (N = 0, 1): request valid and write enable.
REQ-005 The block SHALL have ports pN_addr, pN_wdata, input, 32 bits each: byte address and store data.
REQ-006 The block SHALL have port pN_mode, input, 3 bits, the access mode: 0 signed byte, 1 signed half, 2 word, 4 unsigned byte, 5 unsigned half.
REQ-007 The block SHALL have port pN_gnt, output, 1 bit: the request is accepted this cycle.
REQ-008 The block SHALL have ports pN_rvalid, pN_rerr, output, 1 bit each: response valid and error flag.
REQ-009 The block SHALL have port pN_rdata, output, 32 bits: load result.
REQ-010 The block SHALL have ports ram_we, output, 1 bit; ram_addr, output, 32 bits; ram_mode, output, 3 bits; ram_din, output, 32 bits: RAM command.
REQ-011 The block SHALL have port ram_dout, input, 32 bits: combinational RAM read data, already extended per ram_mode.

Function
REQ-012 The block SHALL assert at most one of p0_gnt, p1_gnt in any cycle, and only for a port whose req is high.
REQ-013 The block SHALL compute gnt combinationally in the same cycle as req, with no idle cycle between back-to-back grants.
REQ-014 The block SHALL keep a two-state priority FSM: P0_PRI (reset state) and P1_PRI.
REQ-015 The block SHALL grant, when both ports request, p0 in P0_PRI and p1 in P1_PRI; a lone requester is always granted.
REQ-016 The block SHALL keep a 4-bit starve counter: +1 in each cycle where p1_req=1 and p1_gnt=0; cleared when p1_gnt=1 or p1_req=0; saturating at STARVE_LIMIT.
REQ-017 The block SHALL move P0_PRI->P1_PRI on the edge where the counter's next value equals STARVE_LIMIT, and P1_PRI->P0_PRI on the edge following any p1 grant.
REQ-018 The block SHALL drive ram_addr, ram_mode and ram_din from the granted port; ram_we = granted pN_we AND legal; when no port is granted, ram_we=0 and the other RAM outputs are 0.
REQ-019 A request SHALL be illegal if: mode is 3, 6 or 7; a half access has addr[0]=1; or a word access has addr[1:0]!=0.
REQ-020 The block SHALL still grant an illegal request, with ram_we forced to 0.
REQ-021 The block SHALL pulse pN_rvalid for exactly one cycle, one cycle after each pN grant, for both reads and writes.
REQ-022 The block SHALL set pN_rerr=1 together with rvalid for an illegal request, otherwise 0.
REQ-023 The block SHALL register pN_rdata on the grant edge: ram_dout for a legal read, 0 for an illegal request, and the previous value unchanged for a legal write.
REQ-024 The block SHALL hold pN_rdata between responses; rerr is valid only while rvalid=1.
REQ-025 A requester SHALL hold req, we, addr, mode and wdata stable until gnt; the block SHALL NOT buffer or queue requests.
REQ-026 A grant cycle followed by a same-port request in the next cycle SHALL be allowed: rvalid of the first request and gnt of the second are asserted in the same cycle.

Reset
REQ-027 While rst=1, the block SHALL hold pN_gnt=0 and ram_we=0, regardless of req.
REQ-028 On a rst=1 edge, the block SHALL set the FSM to P0_PRI, the starve counter to 0, pN_rvalid=0, pN_rerr=0 and pN_rdata=0.
REQ-029 Reset asserted in a grant cycle SHALL cancel that transaction's response: no rvalid pulse and no RAM write.

Verification
REQ-030 Verify: p0 writes word 0x11223344 to 0x10, then p1 reads with mode 4 at 0x13 -> p1_rvalid one cycle after grant, p1_rdata=0x00000011.
REQ-031 Verify: both ports request continuously with STARVE_LIMIT=4 -> p0 granted in cycles 0-3, p1 in cycle 4, p0 in cycle 5; the pattern repeats.
REQ-032 Verify: p0 issues a word read at 0x02 -> p0_gnt=1, ram_we=0, next cycle p0_rvalid=1, p0_rerr=1, p0_rdata=0.
REQ-033 Verify: p1 issues a signed half read of 0x8001 at 0x22 -> p1_rdata=0xFFFF8001, rerr=0.
REQ-034 Verify: rst pulsed in the same cycle as a p0 write grant -> RAM contents unchanged, p0_rvalid stays 0, FSM in P0_PRI, counter 0.
REQ-035 Verify: p1 writes a byte, then issues back-to-back reads -> one rvalid per grant, no idle cycles, rdata holds across the write response.
